// File: rtl/chart_pkg.sv
// chart_pkg: shared widths, end-of-song marker, scheduler states and lane indices
// for the chart playback path.
package chart_pkg;

    localparam int ARROW_W  = 4;
    localparam int TIMING_W = 4;

    // An all-zero chart entry (no arrows, no delay) ends the song.
    localparam logic [ARROW_W+TIMING_W-1:0] END_MARKER = 8'h00;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT,
        FIRE,
        DONE
    } sched_state_e;

    // Bit position of each lane inside an arrow mask.
    localparam int LEFT  = 0;
    localparam int DOWN  = 1;
    localparam int UP    = 2;
    localparam int RIGHT = 3;

endpackage

// File: rtl/chart_scheduler_if.sv
// chart_scheduler_if: bus between the chart ROM stage / control and the scheduler.
// Signal suffixes are written from the scheduler's point of view.
// Optional feature macro: CHART_SCHEDULER_PAUSE_EN (adds pause_i).
interface chart_scheduler_if;
    import chart_pkg::*;

    logic                start_i;
    logic [ARROW_W-1:0]  arrows_i;
    logic [TIMING_W-1:0] timing_i;
    logic                next_o;
    logic [ARROW_W-1:0]  spawn_o;
    logic                beat_o;
    logic                busy_o;
    logic                done_o;

`ifdef CHART_SCHEDULER_PAUSE_EN
    logic                pause_i;

    modport slave (
        input  start_i, arrows_i, timing_i, pause_i,
        output next_o, spawn_o, beat_o, busy_o, done_o
    );

    modport master (
        output start_i, arrows_i, timing_i, pause_i,
        input  next_o, spawn_o, beat_o, busy_o, done_o
    );
`else
    modport slave (
        input  start_i, arrows_i, timing_i,
        output next_o, spawn_o, beat_o, busy_o, done_o
    );

    modport master (
        output start_i, arrows_i, timing_i,
        input  next_o, spawn_o, beat_o, busy_o, done_o
    );
`endif

endinterface

// File: rtl/beat_timer.sv
// beat_timer: free-running beat tick counter. Wraps at BEAT_TICKS_P-1 so the beat
// grid never drifts; clear restarts the grid, hold freezes it without losing phase.
module beat_timer #(
    parameter int BEAT_TICKS_P = 3000000,
    parameter int BEAT_W_P     = 22
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clear_i,
    input  logic enable_i,
    input  logic hold_i,
    output logic tick_o
);
    localparam logic [BEAT_W_P-1:0] LAST_TICK = BEAT_W_P'(BEAT_TICKS_P - 1);

    logic [BEAT_W_P-1:0] count_q;
    logic [BEAT_W_P-1:0] count_d;
    logic                advance;

    assign advance = enable_i && !hold_i;
    assign tick_o  = advance && (count_q == LAST_TICK);

    // Next count: restart on clear, otherwise step and wrap while advancing.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (advance) begin
            count_d = (count_q == LAST_TICK) ? '0 : count_q + BEAT_W_P'(1);
        end
    end

    // Tick counter register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/chart_scheduler.sv
// chart_scheduler: walks the chart one entry at a time, waits each entry's beat
// delay on a drift-free beat timer, then launches its arrows and advances the chart.
// Optional feature macro: CHART_SCHEDULER_PAUSE_EN (pause_i freezes the wait).
module chart_scheduler
    import chart_pkg::*;
#(
    parameter int BEAT_TICKS_P = 3000000,
    parameter int BEAT_W_P     = 22
) (
    input logic              clk_i,
    input logic              reset_i,
    chart_scheduler_if.slave bus
);
    sched_state_e        state_q;
    logic [ARROW_W-1:0]  arrows_q;
    logic [ARROW_W-1:0]  spawn_q;
    logic [TIMING_W-1:0] beatsLeft_q;
    logic                next_q;
    logic                beat_q;
    logic                busy_q;
    logic                done_q;

    logic running;
    logic startReq;
    logic timerHold;
    logic tick;

    // The beat grid runs across LOAD and FIRE too, so per-entry overhead never
    // accumulates; it restarts only when playback is (re)started.
    assign running  = state_q inside {LOAD, WAIT, FIRE};
    assign startReq = bus.start_i && ((state_q == IDLE) || (state_q == DONE));

`ifdef CHART_SCHEDULER_PAUSE_EN
    assign timerHold = bus.pause_i && (state_q == WAIT);
`else
    assign timerHold = 1'b0;
`endif

    beat_timer #(
        .BEAT_TICKS_P(BEAT_TICKS_P),
        .BEAT_W_P    (BEAT_W_P)
    ) u_beat_timer (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clear_i (startReq),
        .enable_i(running),
        .hold_i  (timerHold),
        .tick_o  (tick)
    );

    // Scheduler FSM; every output is a register so the playfield sees clean pulses.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            arrows_q    <= '0;
            beatsLeft_q <= '0;
            spawn_q     <= '0;
            next_q      <= 1'b0;
            beat_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            spawn_q <= '0;
            next_q  <= 1'b0;
            beat_q  <= tick;
            case (state_q)
                IDLE: begin
                    if (startReq) begin
                        state_q <= LOAD;
                        busy_q  <= 1'b1;
                    end
                end
                LOAD: begin
                    arrows_q    <= bus.arrows_i;
                    beatsLeft_q <= bus.timing_i;
                    if ({bus.arrows_i, bus.timing_i} == END_MARKER) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (bus.timing_i == '0) begin
                        state_q <= FIRE;
                        spawn_q <= bus.arrows_i;
                        next_q  <= 1'b1;
                    end else begin
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (tick) begin
                        beatsLeft_q <= beatsLeft_q - TIMING_W'(1);
                        if (beatsLeft_q == TIMING_W'(1)) begin
                            state_q <= FIRE;
                            spawn_q <= arrows_q;
                            next_q  <= 1'b1;
                        end
                    end
                end
                FIRE: begin
                    state_q <= LOAD;
                end
                DONE: begin
                    if (startReq) begin
                        state_q <= LOAD;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.spawn_o = spawn_q;
    assign bus.next_o  = next_q;
    assign bus.beat_o  = beat_q;
    assign bus.busy_o  = busy_q;
    assign bus.done_o  = done_q;

endmodule

// File: tb/tb_chart_scheduler.sv
// tb_chart_scheduler: plays directed and random charts through chart_scheduler and
// compares every cycle against a schedule computed from beat arithmetic.
// Optional feature macro: CHART_SCHEDULER_PAUSE_EN (enables the pause scenario).
module tb_chart_scheduler;
    import chart_pkg::*;

    localparam int TICKS = 4;
    localparam int WIN   = 220;

    logic clock = 1'b0;
    logic reset;

    int checks   = 0;
    int failures = 0;

    logic [7:0] chartMem [0:127];
    logic [7:0] expV [0:WIN-1];

    int chartAddr;
    int firstSpawnCyc;
    int lastSpawnCyc;
    int spawnGap;
    int spawnCount;
    int nextCount;
    int firstNextCyc;

    chart_scheduler_if bus ();

    chart_scheduler #(
        .BEAT_TICKS_P(TICKS),
        .BEAT_W_P    (3)
    ) dut (
        .clk_i  (clock),
        .reset_i(reset),
        .bus    (bus)
    );

    // Free-running bench clock.
    always #5 clock = ~clock;

    function automatic logic [7:0] observed();
        return {bus.spawn_o, bus.next_o, bus.beat_o, bus.busy_o, bus.done_o};
    endfunction

    function automatic logic [7:0] mkEntry(input logic [3:0] arr, input int t);
        return {arr, 4'(t)};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expect_);
        checks++;
        if (obs !== expect_) begin
            failures++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, expect_);
        end
    endtask

    // Expected {spawn,next,beat,busy,done} per cycle, when start is seen in cycle s.
    // Beats fall on a fixed grid anchored at the first LOAD; an entry of t beats
    // fires the cycle after the t-th grid tick strictly after its LOAD cycle.
    function automatic void buildModel(input int startAddr, input int s);
        int firstLoad, load, fire, tickCyc, a, lastRun, doneFrom, t;
        logic [7:0] e;
        for (int i = 0; i < WIN; i++) expV[i] = 8'h00;
        firstLoad = s + 1;
        load      = firstLoad;
        a         = startAddr;
        lastRun   = WIN - 1;
        doneFrom  = WIN;
        while (load < WIN) begin
            e = chartMem[a];
            expV[load][1] = 1'b1;
            if (e == 8'h00) begin
                lastRun  = load;
                doneFrom = load + 1;
                break;
            end
            t = int'(e[3:0]);
            if (t == 0) begin
                fire = load + 1;
            end else begin
                tickCyc = firstLoad + TICKS - 1;
                if (tickCyc <= load) tickCyc += ((load - tickCyc) / TICKS + 1) * TICKS;
                tickCyc += (t - 1) * TICKS;
                fire = tickCyc + 1;
            end
            for (int c = load + 1; c <= fire && c < WIN; c++) expV[c][1] = 1'b1;
            if (fire < WIN) begin
                expV[fire][7:4] = e[7:4];
                expV[fire][3]   = 1'b1;
            end
            a++;
            load = fire + 1;
        end
        for (int c = doneFrom; c < WIN; c++) expV[c][0] = 1'b1;
        for (int c = firstLoad; c <= lastRun && c + 1 < WIN; c++)
            if ((c - firstLoad) % TICKS == TICKS - 1) expV[c + 1][2] = 1'b1;
    endfunction

    task automatic applyReset();
        @(negedge clock);
        reset        = 1'b1;
        bus.start_i  = 1'b0;
`ifdef CHART_SCHEDULER_PAUSE_EN
        bus.pause_i  = 1'b0;
`endif
        @(negedge clock);
        checkOutput("resetState", observed(), 8'h00);
        reset = 1'b0;
    endtask

    // Play a chart from startAddr; the bench acts as the chart stage, advancing
    // its address whenever next_o is seen.
    task automatic applyStimulus(input string name, input int startAddr, input int s,
                                 input int hold, input bit noise, input int nCycles);
        logic [7:0] obs;
        buildModel(startAddr, s);
        chartAddr     = startAddr;
        firstSpawnCyc = -1;
        lastSpawnCyc  = -1;
        spawnGap      = -1;
        spawnCount    = 0;
        nextCount     = 0;
        firstNextCyc  = -1;
        for (int c = 0; c < nCycles; c++) begin
            @(negedge clock);
            obs = observed();
            checkOutput($sformatf("%s_c%0d", name, c), obs, expV[c]);
            if (obs[7:4] != 4'd0) begin
                if (firstSpawnCyc < 0) firstSpawnCyc = c;
                else spawnGap = c - lastSpawnCyc;
                lastSpawnCyc = c;
                spawnCount++;
            end
            if (obs[3]) begin
                if (firstNextCyc < 0) firstNextCyc = c;
                nextCount++;
                chartAddr++;
            end
            bus.start_i  = ((c >= s) && (c < s + hold)) ||
                           (noise && expV[c][1] && ($urandom_range(0, 3) == 0));
            bus.arrows_i = chartMem[chartAddr][7:4];
            bus.timing_i = chartMem[chartAddr][3:0];
        end
    endtask

    initial begin
        int base, n, t;
        logic [3:0] arr;
        reset        = 1'b1;
        bus.start_i  = 1'b0;
        bus.arrows_i = 4'd0;
        bus.timing_i = 4'd0;
`ifdef CHART_SCHEDULER_PAUSE_EN
        bus.pause_i  = 1'b0;
`endif
        for (int i = 0; i < 128; i++) chartMem[i] = 8'h00;

        chartMem[0]  = mkEntry((4'b0001 << LEFT) | (4'b0001 << UP), 2);
        chartMem[1]  = END_MARKER;
        chartMem[2]  = mkEntry(4'b0001 << RIGHT, 0);
        chartMem[3]  = END_MARKER;
        chartMem[4]  = mkEntry(4'b0001 << LEFT, 1);
        chartMem[5]  = mkEntry(4'b0001 << DOWN, 1);
        chartMem[6]  = END_MARKER;
        chartMem[7]  = mkEntry(4'b0000, 3);
        chartMem[8]  = END_MARKER;
        chartMem[9]  = mkEntry(4'b0001 << LEFT, 2);
        chartMem[10] = END_MARKER;

        $display("[TB] directed: two-beat entry");
        applyReset();
        applyStimulus("twoBeat", 0, 0, 1, 1'b0, 20);
        checkOutput("twoBeatSpawnCycle", firstSpawnCyc, 9);
        checkOutput("twoBeatSpawnCount", spawnCount, 1);

        $display("[TB] directed: zero-delay entry");
        applyReset();
        applyStimulus("zeroWait", 2, 0, 1, 1'b0, 12);
        checkOutput("zeroWaitSpawnCycle", firstSpawnCyc, 2);
        checkOutput("zeroWaitSpawnCount", spawnCount, 1);

        $display("[TB] directed: back-to-back beats then end marker");
        applyReset();
        applyStimulus("seq", 4, 0, 1, 1'b0, 20);
        checkOutput("seqFirstSpawn", firstSpawnCyc, 5);
        checkOutput("seqSpawnGap", spawnGap, TICKS);
        checkOutput("seqNextCount", nextCount, 2);
        checkOutput("seqEndBusyDone", {bus.busy_o, bus.done_o}, 2'b01);

        $display("[TB] directed: rest entry");
        applyReset();
        applyStimulus("rest", 7, 0, 1, 1'b0, 20);
        checkOutput("restNextCycle", firstNextCyc, 13);
        checkOutput("restNextCount", nextCount, 1);
        checkOutput("restSpawnCount", spawnCount, 0);

        $display("[TB] directed: reset during wait");
        applyReset();
        applyStimulus("rstWait", 9, 0, 1, 1'b0, 7);
        #2 reset = 1'b1;
        #1 checkOutput("rstWaitAsync", observed(), 8'h00);
        @(negedge clock);
        reset = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            checkOutput($sformatf("rstWaitQuiet_c%0d", c), observed(), 8'h00);
        end

        $display("[TB] directed: reset during fire");
        applyReset();
        applyStimulus("rstFire", 9, 0, 1, 1'b0, 10);
        #2 reset = 1'b1;
        #1 checkOutput("rstFireAsync", observed(), 8'h00);
        @(negedge clock);
        reset = 1'b0;

        for (int r = 0; r < 8; r++) begin
            base = 16 + r * 8;
            n    = int'($urandom_range(1, 6));
            for (int k = 0; k < n; k++) begin
                arr = 4'($urandom_range(0, 15));
                t   = int'($urandom_range(0, 5));
                if (arr == 4'd0 && t == 0) t = 1;
                chartMem[base + k] = mkEntry(arr, t);
            end
            chartMem[base + n] = END_MARKER;
            $display("[TB] random chart %0d with %0d entries", r, n);
            applyReset();
            applyStimulus($sformatf("rand%0d", r), base, int'($urandom_range(0, 3)),
                          int'($urandom_range(1, 2)), 1'b1, WIN);
            checkOutput($sformatf("rand%0dNextCount", r), nextCount, n);
        end

`ifdef CHART_SCHEDULER_PAUSE_EN
        begin
            int beats;
            logic [7:0] obs;
            $display("[TB] directed: pause during wait");
            applyReset();
            chartAddr     = 9;
            firstSpawnCyc = -1;
            beats         = 0;
            for (int c = 0; c < 40; c++) begin
                @(negedge clock);
                obs = observed();
                if (obs[2]) beats++;
                if (obs[7:4] != 4'd0 && firstSpawnCyc < 0) firstSpawnCyc = c;
                if (obs[3]) chartAddr++;
                bus.start_i  = (c == 0);
                bus.pause_i  = (c >= 5) && (c < 15);
                bus.arrows_i = chartMem[chartAddr][7:4];
                bus.timing_i = chartMem[chartAddr][3:0];
            end
            checkOutput("pauseSpawnCycle", firstSpawnCyc, 19);
            checkOutput("pauseBeatCount", beats, 2);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
